// File: rtl/vga_sync_receiver.sv
// VGA capture front end: recovers x/y from hsync/vsync, checks line/frame lengths, gates colour.
// Defining VGA_RX_ERR_CNT_EN adds the saturating o_err_cnt output.
`timescale 1ns/1ps
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 526,
  parameter int H_ACT_FIRST = 145,
  parameter int H_ACT_LAST  = 783,
  parameter int V_ACT_FIRST = 36,
  parameter int V_ACT_LAST  = 514,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [3:0] i_red,
  input  logic [3:0] i_green,
  input  logic [3:0] i_blue,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_pixel_valid,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_line_err
`ifdef VGA_RX_ERR_CNT_EN
  ,
  output logic [7:0] o_err_cnt
`endif
);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} lock_state_t;

  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] H_LAST_CNT  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_CNT  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_FIRST    = 10'(H_ACT_FIRST);
  localparam logic [9:0] HA_LAST     = 10'(H_ACT_LAST);
  localparam logic [9:0] VA_FIRST    = 10'(V_ACT_FIRST);
  localparam logic [9:0] VA_LAST     = 10'(V_ACT_LAST);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  logic        s1_hsync, s1_vsync, s2_hsync;
  logic [3:0]  s1_red, s1_green, s1_blue;
  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  logic        h_aligned, v_aligned, vsync_at_rise;
  logic        hsync_rise, vsync_line;
  logic        line_err, timeout_err, frame_err, any_err;
  logic        pix_valid_d;
  lock_state_t state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s2_hsync <= 1'b0;
      s1_red   <= 4'd0;
      s1_green <= 4'd0;
      s1_blue  <= 4'd0;
    end else begin
      s1_hsync <= i_hsync;
      s1_vsync <= i_vsync;
      s2_hsync <= s1_hsync;
      s1_red   <= i_red;
      s1_green <= i_green;
      s1_blue  <= i_blue;
    end
  end

  // h_cnt passes through 1022 only once per line, so the timeout fires once and re-arms on the next rise.
  always_comb begin
    hsync_rise = s1_hsync & ~s2_hsync;
    vsync_line = hsync_rise & s1_vsync & ~vsync_at_rise;
    if (hsync_rise)
      h_next = 10'd0;
    else
      h_next = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1;
    v_next = v_cnt;
    if (vsync_line)
      v_next = 10'd0;
    else if (hsync_rise && v_cnt != CNT_MAX)
      v_next = v_cnt + 10'd1;
    line_err    = hsync_rise & h_aligned & (h_cnt != H_LAST_CNT);
    timeout_err = ~hsync_rise & h_aligned & (h_cnt == CNT_MAX - 10'd1);
    frame_err   = vsync_line & v_aligned & (v_cnt != V_LAST_CNT);
    any_err     = line_err | timeout_err | frame_err;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt         <= 10'd0;
      v_cnt         <= 10'd0;
      h_aligned     <= 1'b0;
      v_aligned     <= 1'b0;
      vsync_at_rise <= 1'b0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
      if (hsync_rise) begin
        h_aligned     <= 1'b1;
        vsync_at_rise <= s1_vsync;
      end
      if (vsync_line)
        v_aligned <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= UNLOCKED;
      good_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (vsync_line) begin
          state_d    = CHECK;
          good_cnt_d = 4'd0;
        end
      end
      CHECK: begin
        if (any_err) begin
          state_d = UNLOCKED;
        end else if (vsync_line) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_TARGET)
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err)
          state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Validity and lock use the next state so they line up with the beat that caused the change.
  assign pix_valid_d = (state_d == LOCKED) &&
                       (h_next >= HA_FIRST) && (h_next <= HA_LAST) &&
                       (v_next >= VA_FIRST) && (v_next <= VA_LAST);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x           <= 10'd0;
      o_y           <= 10'd0;
      o_pixel_valid <= 1'b0;
      o_red         <= 4'd0;
      o_green       <= 4'd0;
      o_blue        <= 4'd0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_line_err    <= 1'b0;
    end else begin
      o_x           <= h_next;
      o_y           <= v_next;
      o_pixel_valid <= pix_valid_d;
      o_red         <= pix_valid_d ? s1_red   : 4'd0;
      o_green       <= pix_valid_d ? s1_green : 4'd0;
      o_blue        <= pix_valid_d ? s1_blue  : 4'd0;
      o_frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      o_locked      <= (state_d == LOCKED);
      o_line_err    <= any_err;
    end
  end

`ifdef VGA_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err_cnt <= 8'd0;
    else if (any_err && o_err_cnt != 8'hFF)
      o_err_cnt <= o_err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down 40x20 raster: per-beat reference model plus scenario table.
`timescale 1ns/1ps
module tb_vga_sync_receiver;

  localparam int HT = 40, VT = 20, HAF = 8, HAL = 35, VAF = 3, VAL = 17, LF = 2;
  localparam int HS_LEN = 6, VS_LINES = 2;
  localparam int PRE_NONE = 0, PRE_GAP = 1, PRE_RESET = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b0, vsync = 1'b0;
  logic [3:0] red = 4'd0, green = 4'd0, blue = 4'd0;
  logic [9:0] o_x, o_y;
  logic       o_pixel_valid, o_frame_start, o_locked, o_line_err;
  logic [3:0] o_red, o_green, o_blue;
`ifdef VGA_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  always #20 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_FIRST(HAF), .H_ACT_LAST(HAL),
    .V_ACT_FIRST(VAF), .V_ACT_LAST(VAL), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_x(o_x), .o_y(o_y), .o_pixel_valid(o_pixel_valid),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_frame_start(o_frame_start), .o_locked(o_locked), .o_line_err(o_line_err)
`ifdef VGA_RX_ERR_CNT_EN
    , .o_err_cnt(err_cnt)
`endif
  );

  typedef struct {
    int x; int y; bit valid; int r; int g; int b; bit fs; bit locked; bit err; int ecnt;
  } exp_t;

  typedef struct {
    string name; int pre; int frames; int bad_lines; int short_line; int short_len;
    int exp_err; int exp_locked; int exp_valid;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0, errors = 0;
  int   err_seen = 0, valid_seen = 0;
  bit   in_reset = 1'b1, release_pending = 1'b0;

  // Reference model: timestamps of hsync rises and frame-start lines since reset
  int m_n, m_last_rise, m_lines, m_frame_line, m_good, m_errs;
  bit m_prev_hs, m_h_seen, m_v_seen, m_vs_at_rise;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_last_rise = -1; m_lines = 0; m_frame_line = 0; m_good = -1; m_errs = 0;
    m_prev_hs = 0; m_h_seen = 0; m_v_seen = 0; m_vs_at_rise = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input int r, input int g, input int b);
    exp_t e;
    bit   rise, vline, err;
    int   age;
    rise  = hs && !m_prev_hs;
    vline = 1'b0;
    err   = 1'b0;
    age   = m_n - m_last_rise;
    if (rise) begin
      vline = vs && !m_vs_at_rise;
      if (m_h_seen && age != HT) err = 1'b1;
      if (vline && m_v_seen && sat(m_lines - m_frame_line) != VT - 1) err = 1'b1;
      m_lines++;
      if (vline) begin
        m_frame_line = m_lines;
        m_v_seen = 1'b1;
      end
      m_vs_at_rise = vs;
      m_h_seen = 1'b1;
      m_last_rise = m_n;
    end else if (m_h_seen && age == 1023) begin
      err = 1'b1;
    end
    if (m_good < 0) begin
      if (vline) m_good = 0;
    end else if (err) begin
      m_good = -1;
    end else if (vline && m_good < LF) begin
      m_good++;
    end
    e.x      = sat(m_n - m_last_rise);
    e.y      = sat(m_lines - m_frame_line);
    e.locked = (m_good == LF);
    e.valid  = e.locked && e.x >= HAF && e.x <= HAL && e.y >= VAF && e.y <= VAL;
    e.r      = e.valid ? r : 0;
    e.g      = e.valid ? g : 0;
    e.b      = e.valid ? b : 0;
    e.fs     = (e.x == 0) && (e.y == 0);
    e.err    = err;
    if (err && m_errs < 255) m_errs++;
    e.ecnt   = m_errs;
    m_prev_hs = hs;
    m_n++;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    int ecnt;
    ecnt = 0;
`ifdef VGA_RX_ERR_CNT_EN
    ecnt = int'(err_cnt);
`endif
    checkOutput(name, int'(o_x) + int'(o_y) + int'(o_pixel_valid) + int'(o_red) + int'(o_green) +
                int'(o_blue) + int'(o_frame_start) + int'(o_locked) + int'(o_line_err) + ecnt, 0);
  endtask

  task automatic checkBeat();
    exp_t e;
    bit   ok;
    int   ecnt;
    if (exp_q.size() == 0) begin
      checkOutput("beat pipeline depth", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    ecnt = e.ecnt;
`ifdef VGA_RX_ERR_CNT_EN
    ecnt = int'(err_cnt);
`endif
    ok = (int'(o_x) == e.x) && (int'(o_y) == e.y) && (o_pixel_valid == e.valid) &&
         (int'(o_red) == e.r) && (int'(o_green) == e.g) && (int'(o_blue) == e.b) &&
         (o_frame_start == e.fs) && (o_locked == e.locked) && (o_line_err == e.err) &&
         (ecnt == e.ecnt);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL beat t=%0t: got x=%0d y=%0d v=%0b rgb=%0d/%0d/%0d fs=%0b lk=%0b err=%0b ec=%0d, required x=%0d y=%0d v=%0b rgb=%0d/%0d/%0d fs=%0b lk=%0b err=%0b ec=%0d",
               $time, o_x, o_y, o_pixel_valid, o_red, o_green, o_blue, o_frame_start, o_locked,
               o_line_err, ecnt, e.x, e.y, e.valid, e.r, e.g, e.b, e.fs, e.locked, e.err, e.ecnt);
    end
  endtask

  // One pixel per call; the release of a pending reset restarts the model with the reset-state beats.
  task automatic applyStimulus(input logic hs, input logic vs);
    logic [3:0] r, g, b;
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
      in_reset = 1'b0;
      model_reset();
      exp_q.delete();
      exp_q.push_back('{0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0});
      model_step(1'b0, 1'b0, 0, 0, 0);
    end
    if (!in_reset) begin
      checkBeat();
      err_seen   += int'(o_line_err);
      valid_seen += int'(o_pixel_valid);
    end
    r = 4'($urandom);
    g = 4'($urandom);
    b = 4'($urandom);
    hsync = hs; vsync = vs; red = r; green = g; blue = b;
    if (!in_reset) model_step(hs, vs, int'(r), int'(g), int'(b));
  endtask

  task automatic send_frame(input int lines, input int short_line, input int short_len);
    for (int l = 0; l < lines; l++)
      for (int x = 0; x < ((l == short_line) ? short_len : HT); x++)
        applyStimulus(x < HS_LEN, l < VS_LINES);
  endtask

  task automatic hsync_gap();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(1'b0, 1'b0);
      pulses += int'(o_line_err);
    end
    checkOutput("gap timeout pulses", pulses, 1);
    checkOutput("gap x saturated", int'(o_x), 1023);
    checkOutput("gap lock lost", int'(o_locked), 0);
  endtask

  task automatic reset_mid_frame();
    for (int l = 0; l < VT; l++)
      for (int x = 0; x < HT; x++) begin
        if (l == 10 && x == 23) release_pending = 1'b1;
        applyStimulus(x < HS_LEN, l < VS_LINES);
        if (l == 10 && x == 20) begin
          checkOutput("pre-reset pixel valid", int'(o_pixel_valid), 1);
          #5 rst_n = 1'b0;
          in_reset = 1'b1;
          #1 checkResetOutputs("mid-frame reset outputs");
        end
      end
  endtask

  initial begin
    vecs[0] = '{"lock from reset",      PRE_NONE,  3, VT,     -1,     HT,     0, 1, 420};
    vecs[1] = '{"locked clean",         PRE_NONE,  2, VT,     -1,     HT,     0, 1, 840};
    vecs[2] = '{"short line",           PRE_NONE,  4, VT,     10,     HT - 1, 1, 1, 644};
    vecs[3] = '{"short frame and line", PRE_NONE,  5, VT - 1, VT - 2, HT - 1, 1, 1, 840};
    vecs[4] = '{"resume after gap",     PRE_GAP,   3, VT,     -1,     HT,     1, 1, 420};
    vecs[5] = '{"relock after reset",   PRE_RESET, 3, VT,     -1,     HT,     0, 1, 420};

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
    checkResetOutputs("power-on reset outputs");
    release_pending = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre == PRE_GAP) hsync_gap();
      else if (vecs[i].pre == PRE_RESET) reset_mid_frame();
      err_seen = 0;
      valid_seen = 0;
      for (int f = 0; f < vecs[i].frames; f++) begin
        if (f == 0) send_frame(vecs[i].bad_lines, vecs[i].short_line, vecs[i].short_len);
        else        send_frame(VT, -1, HT);
      end
      checkOutput({vecs[i].name, " err pulses"}, err_seen, vecs[i].exp_err);
      checkOutput({vecs[i].name, " locked"}, int'(o_locked), vecs[i].exp_locked);
      checkOutput({vecs[i].name, " valid beats"}, valid_seen, vecs[i].exp_valid);
      $display("[TB] scenario '%s' done", vecs[i].name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
